// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM for the RV32I multicycle core. Sequences the
//               shared datapath and runs the memory ready/req handshake with an
//               optional wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXEC_R   = 4'd6;
    localparam logic [3:0] c_EXEC_I   = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;
    localparam logic [3:0] c_JALR1    = 4'd11;
    localparam logic [3:0] c_JALR2    = 4'd12;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [7:0] c_TIMEOUT      = 8'(MEM_TIMEOUT);
    localparam logic [7:0] c_TIMEOUT_LAST = c_TIMEOUT - 8'd1;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_wait_cnt;
    logic       w_mem_req;
    logic       w_timeout;
    logic       w_taken;
    logic       w_br_illegal;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_instr_done;
    logic       w_illegal;

    assign w_mem_req = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                       (r_state == c_MEMWRITE);
    // Ready in the same cycle as the limit wins, so the timeout needs !mem_ready.
    assign w_timeout = (c_TIMEOUT != 8'd0) && w_mem_req && !mem_ready &&
                       (r_wait_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_taken      = 1'b0;
        w_br_illegal = 1'b0;
        case (funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = !alu_zero;
            3'b100:  w_taken = alu_lt;
            3'b101:  w_taken = !alu_lt;
            3'b110:  w_taken = alu_ltu;
            3'b111:  w_taken = !alu_ltu;
            default: w_br_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_mem_write  = 1'b0;
        adr_src      = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        result_src   = 2'b00;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            c_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) w_next = c_DECODE;
            end
            c_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    c_OP_LOAD, c_OP_STORE: w_next = c_MEMADR;
                    c_OP_R:                w_next = c_EXEC_R;
                    c_OP_I:                w_next = c_EXEC_I;
                    c_OP_BR:               w_next = c_BRANCH;
                    c_OP_JAL:              w_next = c_JAL;
                    c_OP_JALR:             w_next = c_JALR1;
                    c_OP_AUIPC:            w_next = c_ALUWB;
                    default: begin
                        w_next       = c_FETCH;
                        w_illegal    = 1'b1;
                        w_instr_done = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next = c_MEMWB;
                end else if (w_timeout) begin
                    w_next       = c_FETCH;
                    w_instr_done = 1'b1;
                end
            end
            c_MEMWB: begin
                result_src   = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_MEMWRITE: begin
                w_mem_write = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready || w_timeout) begin
                    w_next       = c_FETCH;
                    w_instr_done = 1'b1;
                end
            end
            c_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = c_ALUWB;
            end
            c_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                w_next    = c_ALUWB;
            end
            c_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                w_instr_done = 1'b1;
                w_pc_write   = w_taken;
                w_illegal    = w_br_illegal;
                w_next       = c_FETCH;
            end
            c_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = c_ALUWB;
            end
            c_JALR1: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = c_JALR2;
            end
            c_JALR2: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = c_ALUWB;
            end
            default: w_next = c_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            // A FETCH timeout keeps the state, so it must clear the count explicitly.
            if ((w_next != r_state) || mem_ready || w_timeout) begin
                r_wait_cnt <= 8'd0;
            end else if (w_mem_req) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign mem_req    = w_mem_req    & ~rst;
    assign mem_write  = w_mem_write  & ~rst;
    assign ir_write   = w_ir_write   & ~rst;
    assign pc_write   = w_pc_write   & ~rst;
    assign reg_write  = w_reg_write  & ~rst;
    assign instr_done = w_instr_done & ~rst;
    assign illegal    = w_illegal    & ~rst;
    assign bus_err    = w_timeout    & ~rst;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl, instruction-level
//               model with randomized wait states and branch operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int MT = 4;

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_AUIPC = 7, K_ILL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_done, illegal, bus_err;
    logic [3:0] state;

    int n_chk = 0, n_fail = 0;
    int ncyc, nwait, n_buserr;
    bit aborted;
    logic br_pc_write;

    multicycle_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .instr_done(instr_done),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected control word for one cycle in a given phase of an instruction.
    function automatic logic [20:0] exp_vec(input int st, input bit rdy, input bit to,
                                            input bit taken, input bit ill);
        logic req = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, dn = 0, il = 0, be = 0;
        logic [1:0] a = 0, b = 0, op = 0, res = 0;
        case (st)
            0:  begin req = 1; b = 2; res = 2; irw = rdy; pcw = rdy; be = to; end
            1:  begin a = 1; b = 1; il = ill; dn = ill; end
            2:  begin a = 2; b = 1; end
            3:  begin req = 1; adr = 1; be = to; dn = to; end
            4:  begin res = 1; rw = 1; dn = 1; end
            5:  begin req = 1; mw = 1; adr = 1; dn = rdy | to; be = to; end
            6:  begin a = 2; op = 2; end
            7:  begin a = 2; b = 1; op = 2; end
            8:  begin rw = 1; dn = 1; end
            9:  begin a = 2; op = 1; dn = 1; pcw = taken; il = ill; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: begin a = 2; b = 1; end
            12: begin a = 1; b = 2; pcw = 1; end
            default: ;
        endcase
        return {req, mw, adr, irw, pcw, rw, a, b, op, res, dn, il, be, 4'(st)};
    endfunction

    // Called at a falling edge; compares mid-cycle and returns at the next falling edge.
    task automatic cyc(input int st, input bit rdy, input bit to, input bit taken, input bit ill);
        logic [20:0] act;
        mem_ready = rdy;
        #1;
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
               alu_src_b, alu_op, result_src, instr_done, illegal, bus_err, state};
        chk($sformatf("cycle st=%0d", st), 32'(act), 32'(exp_vec(st, rdy, to, taken, ill)));
        if (st == 9) br_pc_write = pc_write;
        if (bus_err === 1'b1) n_buserr++;
        ncyc++;
        @(negedge clk);
    endtask

    task automatic mem_phase(input int st, input int waits);
        bit rdy, to;
        for (int i = 0; i <= waits; i++) begin
            rdy = (i == waits);
            to  = !rdy && (MT != 0) && ((i % MT) == MT - 1);
            cyc(st, rdy, to, 1'b0, 1'b0);
            if (!rdy) nwait++;
            if (to && st != 0) begin
                aborted = 1;
                break;
            end
        end
    endtask

    task automatic do_instr(input int kind, input int w0, input int w1, input logic [2:0] f3,
                            input logic [31:0] ra, input logic [31:0] rb);
        int  base;
        bit  taken, bill;
        ncyc = 0; nwait = 0; n_buserr = 0; aborted = 0;
        funct3 = f3;
        case (kind)
            K_LOAD:  opcode = 7'b0000011;
            K_STORE: opcode = 7'b0100011;
            K_R:     opcode = 7'b0110011;
            K_I:     opcode = 7'b0010011;
            K_BR:    opcode = 7'b1100011;
            K_JAL:   opcode = 7'b1101111;
            K_JALR:  opcode = 7'b1100111;
            K_AUIPC: opcode = 7'b0010111;
            default: case ($urandom_range(0, 3))
                         0: opcode = 7'b0110111;
                         1: opcode = 7'b0000000;
                         2: opcode = 7'b1110011;
                         default: opcode = 7'b1111111;
                     endcase
        endcase
        alu_zero = (ra == rb);
        alu_lt   = ($signed(ra) < $signed(rb));
        alu_ltu  = (ra < rb);
        bill  = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000: taken = (ra == rb);
            3'b001: taken = (ra != rb);
            3'b100: taken = ($signed(ra) < $signed(rb));
            3'b101: taken = ($signed(ra) >= $signed(rb));
            3'b110: taken = (ra < rb);
            3'b111: taken = (ra >= rb);
            default: taken = 0;
        endcase
        mem_phase(0, w0);
        cyc(1, 1'($urandom), 0, 0, kind == K_ILL);
        base = 2;
        case (kind)
            K_LOAD:  begin cyc(2, 1'($urandom), 0, 0, 0); mem_phase(3, w1);
                           if (!aborted) cyc(4, 1'($urandom), 0, 0, 0); base = 5; end
            K_STORE: begin cyc(2, 1'($urandom), 0, 0, 0); mem_phase(5, w1); base = 4; end
            K_R:     begin cyc(6, 1'($urandom), 0, 0, 0); cyc(8, 1'($urandom), 0, 0, 0); base = 4; end
            K_I:     begin cyc(7, 1'($urandom), 0, 0, 0); cyc(8, 1'($urandom), 0, 0, 0); base = 4; end
            K_BR:    begin cyc(9, 1'($urandom), 0, taken, bill); base = 3; end
            K_JAL:   begin cyc(10, 1'($urandom), 0, 0, 0); cyc(8, 1'($urandom), 0, 0, 0); base = 4; end
            K_JALR:  begin cyc(11, 1'($urandom), 0, 0, 0); cyc(12, 1'($urandom), 0, 0, 0);
                           cyc(8, 1'($urandom), 0, 0, 0); base = 5; end
            K_AUIPC: begin cyc(8, 1'($urandom), 0, 0, 0); base = 3; end
            default: base = 2;
        endcase
        if (!aborted) chk("latency", 32'(ncyc), 32'(base + nwait));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int kind;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Reset arriving mid-store with memory stalled.
        ncyc = 0; opcode = 7'b0100011; funct3 = 3'b010;
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
        chk("in_memwrite", 32'(state), 32'd5);
        rst = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_mem_write", 32'(mem_write), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        rst = 0;
        #1;
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd1);

        // Directed cases with hand-computed latencies.
        do_instr(K_R, 0, 0, 3'b000, 0, 0);
        chk("add_cycles", 32'(ncyc), 32'd4);
        do_instr(K_LOAD, 0, 2, 3'b010, 0, 0);
        chk("lw_cycles", 32'(ncyc), 32'd7);
        do_instr(K_BR, 0, 0, 3'b000, 32'd7, 32'd7);
        chk("beq_pc_write", 32'(br_pc_write), 32'd1);
        chk("beq_cycles", 32'(ncyc), 32'd3);
        do_instr(K_BR, 0, 0, 3'b001, 32'd7, 32'd7);
        chk("bne_pc_write", 32'(br_pc_write), 32'd0);
        chk("bne_cycles", 32'(ncyc), 32'd3);
        do_instr(K_BR, 0, 0, 3'b010, 32'd1, 32'd2);
        chk("br_illegal_pc_write", 32'(br_pc_write), 32'd0);
        do_instr(K_JALR, 0, 0, 3'b000, 0, 0);
        chk("jalr_cycles", 32'(ncyc), 32'd5);
        do_instr(K_STORE, 0, 20, 3'b010, 0, 0);
        chk("sw_timeout_cycles", 32'(ncyc), 32'd7);
        chk("sw_timeout_buserr", 32'(n_buserr), 32'd1);
        do_instr(K_ILL, 0, 0, 3'b000, 0, 0);
        chk("illegal_cycles", 32'(ncyc), 32'd2);
        do_instr(K_AUIPC, 0, 0, 3'b000, 0, 0);
        chk("auipc_cycles", 32'(ncyc), 32'd3);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 8);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_instr(kind, $urandom_range(0, 9), $urandom_range(0, 6),
                     3'($urandom), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
